// File: rtl/freq_meas_pkg.sv
// Shared types and constants for the pulse-train period/high-time meter.
package freq_meas_pkg;

  typedef enum logic {
    FM_ARM  = 1'b0,
    FM_MEAS = 1'b1
  } fm_state_t;

  localparam int unsigned FM_MIN_BITS = 2;
  localparam int unsigned FM_MAX_BITS = 32;

  // All-ones value for a counter of the given width; 32-bit result so it
  // can be sliced down by callers of any supported width.
  function automatic logic [31:0] fm_max(input int unsigned nb);
    if (nb >= 32)
      return 32'hFFFF_FFFF;
    else
      return (32'd1 << nb) - 32'd1;
  endfunction

endpackage

// File: rtl/freq_meas_satcnt.sv
// Saturating up-counter with load-to-one, increment enable and at-max flag.
module freq_meas_satcnt
  import freq_meas_pkg::*;
#(
  parameter int unsigned numBits = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clr,
  input  logic               load1,
  input  logic               inc,
  output logic [numBits-1:0] count,
  output logic               at_max
);

  localparam logic [31:0]        MAX32 = fm_max(numBits);
  localparam logic [numBits-1:0] MAX   = MAX32[numBits-1:0];
  localparam logic [numBits-1:0] ONE   = {{(numBits-1){1'b0}}, 1'b1};

  assign at_max = (count == MAX);

  always_ff @(posedge clock) begin
    if (reset || clr)
      count <= '0;
    else if (load1)
      count <= ONE;
    else if (inc && !at_max)
      count <= count + ONE;
  end

endmodule

// File: rtl/freq_meas.sv
// Measures period and high time of a synchronous pulse train, publishing one
// sample per rising edge of sig once armed.
module freq_meas
  import freq_meas_pkg::*;
#(
  parameter int unsigned numBits = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               en,
  input  logic               sig,
  output logic [numBits-1:0] period,
  output logic [numBits-1:0] high_time,
  output logic               valid,
  output logic               ovf,
  output logic               armed
);

  fm_state_t          state;
  logic               sig_d;
  logic               rise;
  logic               ovf_int;
  logic               meas_step;
  logic [numBits-1:0] cnt;
  logic [numBits-1:0] hcnt;
  logic               cnt_max;
  logic               hcnt_max;

  assign rise      = sig & ~sig_d;
  assign meas_step = en & ~rise & (state == FM_MEAS);

  freq_meas_satcnt #(.numBits(numBits)) u_period_cnt (
    .clock  (clock),
    .reset  (reset),
    .clr    (~en),
    .load1  (en & rise),
    .inc    (meas_step),
    .count  (cnt),
    .at_max (cnt_max)
  );

  freq_meas_satcnt #(.numBits(numBits)) u_high_cnt (
    .clock  (clock),
    .reset  (reset),
    .clr    (~en),
    .load1  (en & rise),
    .inc    (meas_step & sig),
    .count  (hcnt),
    .at_max (hcnt_max)
  );

  // sig_d resets high so a level that is already high at reset release
  // cannot be mistaken for a rising edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= FM_ARM;
      sig_d     <= 1'b1;
      ovf_int   <= 1'b0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      ovf       <= 1'b0;
      armed     <= 1'b0;
    end else begin
      sig_d <= sig;
      valid <= 1'b0;
      if (!en) begin
        state   <= FM_ARM;
        ovf_int <= 1'b0;
        armed   <= 1'b0;
      end else begin
        unique case (state)
          FM_ARM: begin
            if (rise) begin
              state   <= FM_MEAS;
              armed   <= 1'b1;
              ovf_int <= 1'b0;
            end
          end
          FM_MEAS: begin
            if (rise) begin
              period    <= cnt;
              high_time <= hcnt;
              ovf       <= ovf_int;
              valid     <= 1'b1;
              ovf_int   <= 1'b0;
            end else if (cnt_max || (sig && hcnt_max)) begin
              ovf_int <= 1'b1;
            end
          end
          default: begin
            state <= FM_ARM;
            armed <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
